// File: rtl/ofifo_drain_ctrl.sv
// OFIFO-to-PMEM drain controller: pops num_vec PSUM vectors and writes them
// into a descending PMEM address window whose lowest address is base_addr.
module ofifo_drain_ctrl #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int num_vec = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [10:0]              base_addr,
    input  logic                     flush,
    input  logic                     ofifo_valid,
    output logic                     ofifo_rd,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    output logic                     CEN_pmem,
    output logic                     WEN_pmem,
    output logic [10:0]              A_pmem,
    output logic [col*psum_bw-1:0]   D_pmem,
    output logic                     busy,
    output logic                     done,
    output logic [4:0]               vec_cnt
);

    localparam logic [10:0] TopOffset = 11'(num_vec - 1);
    localparam logic [4:0]  NumVec    = 5'(num_vec);

    typedef enum logic [1:0] {IDLE, POP, WRITE, FINISH} state_e;

    state_e                 state_q, state_d;
    logic [10:0]            addr_q, addr_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [10:0]            a_hold_q, a_hold_d;
    logic [col*psum_bw-1:0] d_hold_q, d_hold_d;
    logic [4:0]             cnt_inc;

    assign cnt_inc = cnt_q + 5'd1;
    assign vec_cnt = cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            a_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            a_hold_q <= a_hold_d;
            d_hold_q <= d_hold_d;
        end
    end

    // The PMEM port is only driven live in WRITE; elsewhere it replays the
    // last address/data so the SRAM pins stay quiet between drains.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        a_hold_d = a_hold_q;
        d_hold_d = d_hold_q;
        ofifo_rd = 1'b0;
        CEN_pmem = 1'b1;
        WEN_pmem = 1'b1;
        A_pmem   = a_hold_q;
        D_pmem   = d_hold_q;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d = POP;
                    addr_d  = base_addr + TopOffset;
                    cnt_d   = '0;
                end
            end
            POP: begin
                busy = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (ofifo_valid) begin
                    ofifo_rd = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                busy     = 1'b1;
                CEN_pmem = 1'b0;
                WEN_pmem = 1'b0;
                A_pmem   = addr_q;
                D_pmem   = ofifo_out;
                a_hold_d = addr_q;
                d_hold_d = ofifo_out;
                addr_d   = addr_q - 11'd1;
                cnt_d    = cnt_inc;
                // A flushed write still lands this cycle; only the follow-on pop is dropped.
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc < NumVec) begin
                    if (ofifo_valid) begin
                        ofifo_rd = 1'b1;
                        state_d  = WRITE;
                    end else begin
                        state_d  = POP;
                    end
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done    = !flush;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Scoreboard bench for ofifo_drain_ctrl: stimulus queues expected PMEM writes,
// a negedge monitor pops and compares them whenever the DUT writes.
module tb_ofifo_drain_ctrl;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int NUM_VEC = 8;
    localparam int DW      = COL * PSUM_BW;

    logic          clk = 1'b0;
    logic          reset, start, flush, ofifo_valid;
    logic          ofifo_rd, CEN_pmem, WEN_pmem, busy, done;
    logic [10:0]   base_addr, A_pmem;
    logic [DW-1:0] ofifo_out = '0;
    logic [DW-1:0] D_pmem;
    logic [4:0]    vec_cnt;

    int   checks     = 0;
    int   errors     = 0;
    int   writeCount = 0;
    int   doneCount  = 0;
    logic popPending = 1'b0;

    logic [10:0]   expAddrQ[$];
    logic [DW-1:0] expDataQ[$];
    logic [DW-1:0] fifoQ[$];

    logic [10:0] t1Addr [NUM_VEC] = '{11'd7, 11'd6, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1, 11'd0};
    logic [10:0] t3Addr [NUM_VEC] = '{11'd3, 11'd2, 11'd1, 11'd0, 11'd2047, 11'd2046, 11'd2045, 11'd2044};

    ofifo_drain_ctrl #(.col(COL), .psum_bw(PSUM_BW), .num_vec(NUM_VEC)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .flush       (flush),
        .ofifo_valid (ofifo_valid),
        .ofifo_rd    (ofifo_rd),
        .ofifo_out   (ofifo_out),
        .CEN_pmem    (CEN_pmem),
        .WEN_pmem    (WEN_pmem),
        .A_pmem      (A_pmem),
        .D_pmem      (D_pmem),
        .busy        (busy),
        .done        (done),
        .vec_cnt     (vec_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pattern(input int test, input int k);
        logic [DW-1:0] v;
        v = '0;
        for (int l = 0; l < COL; l++) v[l*PSUM_BW +: PSUM_BW] = 16'(test*4096 + k*16 + l);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadFifo(input int test);
        fifoQ.delete();
        for (int k = 0; k < NUM_VEC; k++) fifoQ.push_back(pattern(test, k));
    endtask

    task automatic expectWrite(input logic [10:0] addr, input logic [DW-1:0] data);
        expAddrQ.push_back(addr);
        expDataQ.push_back(data);
    endtask

    // OFIFO model: a pop seen in one cycle presents the next vector in the following cycle.
    initial forever begin
        @(posedge clk);
        if (popPending) begin
            #1;
            if (fifoQ.size() > 0) begin
                ofifo_out = fifoQ.pop_front();
            end else begin
                checks++;
                errors++;
                $display("[TB] FAIL ofifo underflow: got pop, required no pop");
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!CEN_pmem) begin
            writeCount++;
            checkOutput("WEN_pmem on write", WEN_pmem, 1'b0);
            if (expAddrQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected write: got addr %0d, required no write", A_pmem);
            end else begin
                checkOutput("write addr", A_pmem, expAddrQ.pop_front());
                checkOutput("write data", D_pmem, expDataQ.pop_front());
            end
        end
        if (ofifo_rd) checkOutput("ofifo_rd needs valid", ofifo_valid, 1'b1);
        if (done) doneCount++;
        popPending = ofifo_rd;
    end

    // validMode 0 holds ofifo_valid high, 1 toggles it every cycle; extra start pulses at s1/s2.
    task automatic applyStimulus(input logic [10:0] base, input int validMode, input int maxCycles,
                                 input int s1, input int s2,
                                 output int doneCyc, output int writes, output int dones,
                                 output int windowWrites, output logic busyAtDone);
        int w0, d0;
        w0 = writeCount;
        d0 = doneCount;
        doneCyc = -1;
        windowWrites = 0;
        busyAtDone = 1'bx;
        base_addr = base;
        ofifo_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= maxCycles; c++) begin
            if (done && doneCyc < 0) begin
                doneCyc = c;
                busyAtDone = busy;
            end
            if (!CEN_pmem && c >= 2 && c <= NUM_VEC + 1) windowWrites++;
            start = (c == s1 || c == s2);
            if (validMode == 1) ofifo_valid = ~ofifo_valid;
            tick();
        end
        start = 1'b0;
        writes = writeCount - w0;
        dones = doneCount - d0;
    endtask

    initial begin
        int doneCyc, writes, dones, window, w0, d0;
        logic busyAtDone;

        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        ofifo_valid = 1'b0;
        base_addr = '0;
        tick();
        tick();
        checkOutput("reset ofifo_rd", ofifo_rd, 1'b0);
        checkOutput("reset CEN_pmem", CEN_pmem, 1'b1);
        checkOutput("reset WEN_pmem", WEN_pmem, 1'b1);
        checkOutput("reset A_pmem", A_pmem, 11'd0);
        checkOutput("reset D_pmem", D_pmem, '0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset vec_cnt", vec_cnt, 5'd0);
        reset = 1'b1;
        tick();

        // Continuous valid from base 0.
        loadFifo(1);
        for (int k = 0; k < NUM_VEC; k++) expectWrite(t1Addr[k], pattern(1, k));
        applyStimulus(11'd0, 0, 14, 0, 0, doneCyc, writes, dones, window, busyAtDone);
        checkOutput("T1 done cycle", doneCyc, 10);
        checkOutput("T1 busy in FINISH", busyAtDone, 1'b0);
        checkOutput("T1 writes", writes, 8);
        checkOutput("T1 consecutive writes", window, 8);
        checkOutput("T1 done pulses", dones, 1);
        checkOutput("T1 scoreboard drained", expAddrQ.size(), 0);

        // Valid toggling every cycle.
        loadFifo(2);
        for (int k = 0; k < NUM_VEC; k++) expectWrite(11'(107 - k), pattern(2, k));
        applyStimulus(11'd100, 1, 40, 0, 0, doneCyc, writes, dones, window, busyAtDone);
        ofifo_valid = 1'b0;
        checkOutput("T2 writes", writes, 8);
        checkOutput("T2 done pulses", dones, 1);
        checkOutput("T2 scoreboard drained", expAddrQ.size(), 0);

        // Address window wrapping past 2047.
        loadFifo(3);
        for (int k = 0; k < NUM_VEC; k++) expectWrite(t3Addr[k], pattern(3, k));
        applyStimulus(11'd2044, 0, 14, 0, 0, doneCyc, writes, dones, window, busyAtDone);
        checkOutput("T3 done cycle", doneCyc, 10);
        checkOutput("T3 writes", writes, 8);
        checkOutput("T3 done pulses", dones, 1);
        checkOutput("T3 scoreboard drained", expAddrQ.size(), 0);

        // Flush in the POP cycle following the third write.
        loadFifo(4);
        for (int k = 0; k < 3; k++) expectWrite(11'(23 - k), pattern(4, k));
        w0 = writeCount;
        d0 = doneCount;
        base_addr = 11'd16;
        ofifo_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        ofifo_valid = 1'b0;
        tick();
        checkOutput("T4 vec_cnt before flush", vec_cnt, 5'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("T4 busy after flush", busy, 1'b0);
        checkOutput("T4 vec_cnt after flush", vec_cnt, 5'd0);
        ofifo_valid = 1'b1;
        repeat (12) tick();
        checkOutput("T4 writes", writeCount - w0, 3);
        checkOutput("T4 done pulses", doneCount - d0, 0);
        checkOutput("T4 busy stays low", busy, 1'b0);
        checkOutput("T4 scoreboard drained", expAddrQ.size(), 0);

        // Asynchronous reset in the middle of the third write.
        loadFifo(5);
        expectWrite(11'd47, pattern(5, 0));
        expectWrite(11'd46, pattern(5, 1));
        w0 = writeCount;
        base_addr = 11'd40;
        ofifo_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #1 reset = 1'b0;
        #1;
        checkOutput("T5 CEN_pmem async", CEN_pmem, 1'b1);
        checkOutput("T5 ofifo_rd async", ofifo_rd, 1'b0);
        checkOutput("T5 busy async", busy, 1'b0);
        checkOutput("T5 A_pmem async", A_pmem, 11'd0);
        checkOutput("T5 vec_cnt async", vec_cnt, 5'd0);
        tick();
        tick();
        checkOutput("T5 writes before reset", writeCount - w0, 2);
        checkOutput("T5 scoreboard drained", expAddrQ.size(), 0);
        fifoQ.delete();
        reset = 1'b1;
        repeat (5) tick();
        checkOutput("T5 idle after release", busy, 1'b0);
        checkOutput("T5 no resumed writes", writeCount - w0, 2);
        loadFifo(6);
        for (int k = 0; k < NUM_VEC; k++) expectWrite(11'(47 - k), pattern(6, k));
        applyStimulus(11'd40, 0, 14, 0, 0, doneCyc, writes, dones, window, busyAtDone);
        checkOutput("T5 redrain done cycle", doneCyc, 10);
        checkOutput("T5 redrain writes", writes, 8);
        checkOutput("T5 redrain done pulses", dones, 1);
        checkOutput("T5 redrain scoreboard drained", expAddrQ.size(), 0);

        // Start pulses while busy and during FINISH are ignored.
        loadFifo(7);
        for (int k = 0; k < NUM_VEC; k++) expectWrite(11'(207 - k), pattern(7, k));
        applyStimulus(11'd200, 0, 16, 4, 10, doneCyc, writes, dones, window, busyAtDone);
        checkOutput("T6 done cycle", doneCyc, 10);
        checkOutput("T6 writes", writes, 8);
        checkOutput("T6 done pulses", dones, 1);
        checkOutput("T6 idle after drain", busy, 1'b0);
        checkOutput("T6 scoreboard drained", expAddrQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
